// File: rtl/initialize_storage.sv
// -----------------------------------------------------------------------------
// initialize_storage
//
// Cuckoo-hash placement engine. Two key tables (A and B, DEPTH slots each,
// key value 0 marks an empty slot) plus SLOTS location records that map a key
// to its A-index and B-index. An insert places the key into table A; each
// displaced key is looked up and pushed into its slot in the other table,
// alternating B/A, until an empty slot is hit, a displaced key has no record,
// or MAX_KICKS table writes have been made.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   init              one-cycle pulse: clears both tables, aborts any insert
//   rec_we/rec_addr   record write (IDLE only) of {rec_ia, rec_ib, rec_key}
//   ins_valid/ins_key insert request; accepted when ins_valid && ins_ready
//   ins_ready         high while the engine is idle
//   done              one-cycle completion pulse
//   status            00 placed, 01 no record, 10 kick limit, 11 zero key
//   kicks             table writes made by the last completed insert
//   out_key           key left unplaced (0 when placed)
//   rd_sel/rd_addr    combinational table read port (0 = A, 1 = B)
//   rd_data           table contents, 0 when rd_addr >= DEPTH
//   dbg_state         current FSM state (IDLE=0, LOOKUP=1, PLACE=2, DONE=3)
//
// Handshake: an insert transfers on the rising edge where ins_valid and
// ins_ready are both high; ins_ready drops until the cycle after done.
// -----------------------------------------------------------------------------
module initialize_storage #(
  parameter int KEY_W     = 8,
  parameter int DEPTH     = 10,
  parameter int SLOTS     = 8,
  parameter int MAX_KICKS = 20,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int REC_W    = $clog2(SLOTS),
  localparam int KCNT_W   = $clog2(MAX_KICKS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              rec_we,
  input  logic [REC_W-1:0]  rec_addr,
  input  logic [IDX_W-1:0]  rec_ia,
  input  logic [IDX_W-1:0]  rec_ib,
  input  logic [KEY_W-1:0]  rec_key,
  input  logic              ins_valid,
  input  logic [KEY_W-1:0]  ins_key,
  output logic              ins_ready,
  output logic              done,
  output logic [1:0]        status,
  output logic [KCNT_W-1:0] kicks,
  output logic [KEY_W-1:0]  out_key,
  input  logic              rd_sel,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [KEY_W-1:0]  rd_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_PLACE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] ST_PLACED = 2'b00;
  localparam logic [1:0] ST_NOREC  = 2'b01;
  localparam logic [1:0] ST_LIMIT  = 2'b10;
  localparam logic [1:0] ST_ZERO   = 2'b11;

  state_t              state_q;

  // Key tables
  logic [KEY_W-1:0]    tab_a_q [DEPTH];
  logic [KEY_W-1:0]    tab_b_q [DEPTH];

  // Location records
  logic [SLOTS-1:0]    rec_v_q;
  logic [IDX_W-1:0]    rec_ia_q  [SLOTS];
  logic [IDX_W-1:0]    rec_ib_q  [SLOTS];
  logic [KEY_W-1:0]    rec_key_q [SLOTS];

  // Insert working state
  logic [KEY_W-1:0]    carry_q;
  logic                side_q;       // 0 = next write goes to A, 1 = to B
  logic [IDX_W-1:0]    idx_a_q;
  logic [IDX_W-1:0]    idx_b_q;
  logic [KCNT_W-1:0]   cnt_q;
  logic [KCNT_W-1:0]   cnt_d;

  // Registered result outputs
  logic                done_q;
  logic [1:0]          status_q;
  logic [KCNT_W-1:0]   kicks_q;
  logic [KEY_W-1:0]    out_key_q;

  // Combinational helpers
  logic                rec_ok;
  logic [IDX_W-1:0]    wr_idx;
  logic [KEY_W-1:0]    evicted;
  logic [KEY_W-1:0]    lk_key;
  logic                lk_hit;
  logic [IDX_W-1:0]    lk_ia;
  logic [IDX_W-1:0]    lk_ib;

  assign rec_ok  = (int'(rec_ia) < DEPTH) && (int'(rec_ib) < DEPTH) && (rec_key != '0);
  assign wr_idx  = side_q ? idx_b_q : idx_a_q;
  assign evicted = side_q ? tab_b_q[wr_idx] : tab_a_q[wr_idx];
  assign cnt_d   = cnt_q + KCNT_W'(1);

  // In PLACE the key being chased is the one about to be evicted, so the next
  // hop's indices are known in the same cycle as the write.
  assign lk_key  = (state_q == S_PLACE) ? evicted : carry_q;

  // Scanning from the top down lets the lowest-numbered match win.
  always_comb begin
    lk_hit = 1'b0;
    lk_ia  = '0;
    lk_ib  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (rec_v_q[i] && (rec_key_q[i] == lk_key)) begin
        lk_hit = 1'b1;
        lk_ia  = rec_ia_q[i];
        lk_ib  = rec_ib_q[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < DEPTH) begin
      rd_data = rd_sel ? tab_b_q[rd_addr] : tab_a_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      carry_q   <= '0;
      side_q    <= 1'b0;
      idx_a_q   <= '0;
      idx_b_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      status_q  <= ST_PLACED;
      kicks_q   <= '0;
      out_key_q <= '0;
      rec_v_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tab_a_q[i] <= '0;
        tab_b_q[i] <= '0;
      end
      for (int i = 0; i < SLOTS; i++) begin
        rec_ia_q[i]  <= '0;
        rec_ib_q[i]  <= '0;
        rec_key_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      // Record programming is independent of init, so both can land together.
      if (rec_we && rec_ok && (state_q == S_IDLE)) begin
        rec_v_q[rec_addr]   <= 1'b1;
        rec_ia_q[rec_addr]  <= rec_ia;
        rec_ib_q[rec_addr]  <= rec_ib;
        rec_key_q[rec_addr] <= rec_key;
      end

      if (init) begin
        // Abort: results of the interrupted insert are never published.
        for (int i = 0; i < DEPTH; i++) begin
          tab_a_q[i] <= '0;
          tab_b_q[i] <= '0;
        end
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (ins_valid) begin
              carry_q <= ins_key;
              cnt_q   <= '0;
              side_q  <= 1'b0;
              state_q <= S_LOOKUP;
            end
          end

          // A zero key also passes through here so every insert that makes
          // no table write has the same latency.
          S_LOOKUP: begin
            if (carry_q == '0) begin
              status_q  <= ST_ZERO;
              kicks_q   <= '0;
              out_key_q <= '0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else if (!lk_hit) begin
              status_q  <= ST_NOREC;
              kicks_q   <= '0;
              out_key_q <= carry_q;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              idx_a_q <= lk_ia;
              idx_b_q <= lk_ib;
              state_q <= S_PLACE;
            end
          end

          S_PLACE: begin
            if (side_q) tab_b_q[wr_idx] <= carry_q;
            else        tab_a_q[wr_idx] <= carry_q;
            cnt_q <= cnt_d;
            if (evicted == '0) begin
              status_q  <= ST_PLACED;
              kicks_q   <= cnt_d;
              out_key_q <= '0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else if (cnt_d == KCNT_W'(MAX_KICKS)) begin
              status_q  <= ST_LIMIT;
              kicks_q   <= cnt_d;
              out_key_q <= evicted;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else if (!lk_hit) begin
              status_q  <= ST_NOREC;
              kicks_q   <= cnt_d;
              out_key_q <= evicted;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              carry_q <= evicted;
              idx_a_q <= lk_ia;
              idx_b_q <= lk_ib;
              side_q  <= ~side_q;
            end
          end

          S_DONE: begin
            state_q <= S_IDLE;
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ins_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign status    = status_q;
  assign kicks     = kicks_q;
  assign out_key   = out_key_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_initialize_storage.sv
// -----------------------------------------------------------------------------
// Testbench for initialize_storage. A reference model of the tables and
// records computes each insert's outcome and pushes {status, kicks, out_key}
// into exp_q; a monitor pops and compares whenever done pulses.
// -----------------------------------------------------------------------------
module tb_initialize_storage;

  localparam int MAX_KICKS = 20;
  localparam int DEPTH     = 10;
  localparam int SLOTS     = 8;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       init = 1'b0;
  logic       rec_we = 1'b0;
  logic [2:0] rec_addr = '0;
  logic [3:0] rec_ia = '0;
  logic [3:0] rec_ib = '0;
  logic [7:0] rec_key = '0;
  logic       ins_valid = 1'b0;
  logic [7:0] ins_key = '0;
  logic       ins_ready;
  logic       done;
  logic [1:0] status;
  logic [4:0] kicks;
  logic [7:0] out_key;
  logic       rd_sel = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [1:0] dbg_state;

  initialize_storage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .rec_we    (rec_we),
    .rec_addr  (rec_addr),
    .rec_ia    (rec_ia),
    .rec_ib    (rec_ib),
    .rec_key   (rec_key),
    .ins_valid (ins_valid),
    .ins_key   (ins_key),
    .ins_ready (ins_ready),
    .done      (done),
    .status    (status),
    .kicks     (kicks),
    .out_key   (out_key),
    .rd_sel    (rd_sel),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------- model
  logic [7:0] m_tab [2][DEPTH];
  bit         m_rv  [SLOTS];
  logic [3:0] m_ia  [SLOTS];
  logic [3:0] m_ib  [SLOTS];
  logic [7:0] m_key [SLOTS];
  logic [1:0] m_status;
  logic [4:0] m_kicks;
  logic [7:0] m_outkey;

  logic [14:0] exp_q[$];

  function automatic void m_clear_tables();
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < DEPTH; a++) m_tab[s][a] = 8'h00;
  endfunction

  function automatic void m_reset();
    m_clear_tables();
    for (int i = 0; i < SLOTS; i++) begin
      m_rv[i] = 1'b0; m_ia[i] = '0; m_ib[i] = '0; m_key[i] = '0;
    end
    m_status = 2'b00; m_kicks = '0; m_outkey = '0;
  endfunction

  function automatic bit m_find(input logic [7:0] k, output logic [3:0] ia,
                                output logic [3:0] ib);
    bit hit = 1'b0;
    ia = '0; ib = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!hit && m_rv[i] && m_key[i] == k) begin
        hit = 1'b1; ia = m_ia[i]; ib = m_ib[i];
      end
    end
    return hit;
  endfunction

  // Plays the whole cuckoo chain on the model tables in one call.
  function automatic void m_insert(input logic [7:0] key, output logic [1:0] st,
                                   output int kk, output logic [7:0] ok);
    logic [7:0] carry, ev;
    logic [3:0] ia, ib, idx;
    int side;
    bit fin;
    st = 2'b00; kk = 0; ok = 8'h00;
    if (key == 8'h00) begin
      st = 2'b11;
    end else if (!m_find(key, ia, ib)) begin
      st = 2'b01; ok = key;
    end else begin
      carry = key; side = 0; fin = 1'b0;
      while (!fin) begin
        idx = (side == 1) ? ib : ia;
        ev = m_tab[side][idx];
        m_tab[side][idx] = carry;
        kk++;
        if (ev == 8'h00) begin
          st = 2'b00; ok = 8'h00; fin = 1'b1;
        end else if (kk == MAX_KICKS) begin
          st = 2'b10; ok = ev; fin = 1'b1;
        end else if (!m_find(ev, ia, ib)) begin
          st = 2'b01; ok = ev; fin = 1'b1;
        end else begin
          carry = ev; side = 1 - side;
        end
      end
    end
  endfunction

  // ---------------------------------------------------------------- checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [14:0] e;
    if (rst_n && done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done actual={%0h,%0d,%0h} expected=none",
                 status, kicks, out_key);
      end else begin
        e = exp_q.pop_front();
        if ({status, kicks, out_key} !== e) begin
          errors++;
          $display("FAIL result actual={st=%0h k=%0d key=%0h} expected={st=%0h k=%0d key=%0h}",
                   status, kicks, out_key, e[14:13], e[12:8], e[7:0]);
        end
      end
    end
  end

  task automatic check_tables(input string tag);
    logic [7:0] e;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        rd_sel = s[0]; rd_addr = a[3:0];
        #1;
        e = (a < DEPTH) ? m_tab[s][a] : 8'h00;
        chk($sformatf("%s_rd_%s%0d", tag, (s == 1) ? "B" : "A", a), rd_data, e);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_status"}, status, m_status);
    chk({tag, "_kicks"}, kicks, m_kicks);
    chk({tag, "_out_key"}, out_key, m_outkey);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rec_write(input logic [2:0] a, input logic [3:0] ia,
                           input logic [3:0] ib, input logic [7:0] k);
    @(negedge clk);
    rec_we = 1'b1; rec_addr = a; rec_ia = ia; rec_ib = ib; rec_key = k;
    @(posedge clk);
    #1 rec_we = 1'b0;
    if (ia < DEPTH && ib < DEPTH && k != 8'h00) begin
      m_rv[a] = 1'b1; m_ia[a] = ia; m_ib[a] = ib; m_key[a] = k;
    end
  endtask

  task automatic pulse_init(input bit with_rec, input logic [2:0] a,
                            input logic [3:0] ia, input logic [3:0] ib,
                            input logic [7:0] k);
    @(negedge clk);
    init = 1'b1;
    if (with_rec) begin
      rec_we = 1'b1; rec_addr = a; rec_ia = ia; rec_ib = ib; rec_key = k;
    end
    @(posedge clk);
    #1 init = 1'b0; rec_we = 1'b0;
    m_clear_tables();
    if (with_rec && ia < DEPTH && ib < DEPTH && k != 8'h00) begin
      m_rv[a] = 1'b1; m_ia[a] = ia; m_ib[a] = ib; m_key[a] = k;
    end
  endtask

  // Issues one insert, pushes the model's expectation and checks latency.
  // Latency counts edges after the accepting edge: 1 with no writes, N+1
  // for N writes (i.e. done in cycle 2 / N+2 with the accept cycle as 1).
  task automatic do_insert(input logic [7:0] key);
    logic [1:0] st;
    int kk, cyc, n;
    logic [7:0] ok;
    bit got;
    @(negedge clk);
    n = 0;
    while (ins_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ins_ready !== 1'b1) chk("ready_before_insert", ins_ready, 1);
    m_insert(key, st, kk, ok);
    m_status = st; m_kicks = kk[4:0]; m_outkey = ok;
    exp_q.push_back({st, kk[4:0], ok});
    ins_valid = 1'b1; ins_key = key;
    @(posedge clk);
    #1 ins_valid = 1'b0; ins_key = 8'($urandom);
    cyc = 0; got = 1'b0;
    while (!got && cyc < 64) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
        #1;
      end
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk($sformatf("latency_key%0h", key), cyc, (kk == 0) ? 1 : kk + 1);
      @(posedge clk);
      #1 chk("ready_after_done", ins_ready, 1);
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [2:0] ra;
    logic [3:0] ia, ib;
    logic [7:0] rk;

    do_reset();

    // Reset state
    @(negedge clk);
    chk("reset_ins_ready", ins_ready, 1);
    chk("reset_done", done, 0);
    check_outputs("reset");
    check_tables("reset");

    // Single placement, then one eviction into B
    rec_write(3'd0, 4'd2, 4'd5, 8'h11);
    do_insert(8'h11);
    check_outputs("ins11");
    check_tables("ins11");
    rec_write(3'd1, 4'd2, 4'd7, 8'h22);
    do_insert(8'h22);
    check_outputs("ins22");
    check_tables("ins22");

    // Key with no record
    do_insert(8'h33);
    check_outputs("ins33");
    check_tables("ins33");

    // Three keys sharing one slot pair: third insert runs to the kick limit
    rec_write(3'd0, 4'd1, 4'd1, 8'h11);
    rec_write(3'd1, 4'd1, 4'd1, 8'h22);
    rec_write(3'd2, 4'd1, 4'd1, 8'h33);
    do_insert(8'h11);
    do_insert(8'h22);
    do_insert(8'h33);
    check_outputs("limit");
    chk("limit_status_const", status, 2'b10);
    chk("limit_kicks_const", kicks, 20);
    check_tables("limit");

    // init during PLACE aborts without a done pulse; records survive
    @(negedge clk);
    ins_valid = 1'b1; ins_key = 8'h11;
    @(posedge clk);
    #1 ins_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_in_place", dbg_state, 2);
    pulse_init(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    chk("abort_ins_ready", ins_ready, 1);
    check_outputs("abort_hold");
    check_tables("abort");
    repeat (25) @(negedge clk);
    do_insert(8'h11);
    check_outputs("reins11");
    check_tables("reins11");

    // init and record write together both land
    pulse_init(1'b1, 3'd3, 4'd3, 4'd4, 8'h55);
    do_insert(8'h55);
    check_outputs("init_rec");
    check_tables("init_rec");

    // Illegal record writes are dropped; zero key reports status 11
    rec_write(3'd4, 4'd12, 4'd1, 8'h44);
    rec_write(3'd5, 4'd0, 4'd10, 8'h66);
    rec_write(3'd6, 4'd1, 4'd1, 8'h00);
    do_insert(8'h44);
    do_insert(8'h66);
    do_insert(8'h00);
    check_outputs("zero_key");
    check_tables("illegal");

    // Randomized traffic over a small key space to force chains
    pulse_init(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < SLOTS; i++) begin
      rec_write(i[2:0], 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                8'($urandom_range(1, 12)));
    end
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = 3'($urandom_range(0, 7));
        ia = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        ib = 4'($urandom_range(0, 9));
        rk = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 12));
        rec_write(ra, ia, ib, rk);
      end
      if ($urandom_range(0, 14) == 0) pulse_init(1'b0, '0, '0, '0, '0);
      do_insert(8'($urandom_range(0, 12)));
      if (n % 6 == 5) check_tables($sformatf("rand%0d", n));
    end
    check_outputs("rand_end");

    // Asynchronous reset in the middle of an insert
    rec_write(3'd0, 4'd1, 4'd1, 8'h11);
    rec_write(3'd1, 4'd1, 4'd1, 8'h22);
    do_insert(8'h11);
    @(negedge clk);
    ins_valid = 1'b1; ins_key = 8'h22;
    @(posedge clk);
    #1 ins_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("midrst_ins_ready", ins_ready, 1);
    chk("midrst_done", done, 0);
    check_outputs("midrst");
    check_tables("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    do_insert(8'h11);
    check_outputs("after_rst");

    repeat (4) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound on the run
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
